// File: rtl/tl_chk_pkg.sv
// ============================================================================
//  Module      : tl_chk_pkg
//  Description : Shared TileLink opcodes, error codes and helper functions
//                for the in-flight request checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tl_chk_pkg;

    // TileLink A channel opcodes
    localparam logic [2:0] A_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] A_ARITHMETIC_DATA  = 3'd2;
    localparam logic [2:0] A_LOGICAL_DATA     = 3'd3;
    localparam logic [2:0] A_GET              = 3'd4;
    localparam logic [2:0] A_INTENT           = 3'd5;
    localparam logic [2:0] A_ACQUIRE_BLOCK    = 3'd6;
    localparam logic [2:0] A_ACQUIRE_PERM     = 3'd7;

    // TileLink D channel opcodes
    localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;
    localparam logic [2:0] D_HINT_ACK         = 3'd2;
    localparam logic [2:0] D_GRANT            = 3'd4;
    localparam logic [2:0] D_GRANT_DATA       = 3'd5;
    localparam logic [2:0] D_RELEASE_ACK      = 3'd6;

    localparam int ERR_NUM = 5;

    typedef enum logic [2:0] {
        ERR_NONE            = 3'd0,
        ERR_DUP_SOURCE      = 3'd1,
        ERR_ORPHAN_D        = 3'd2,
        ERR_OPCODE_MISMATCH = 3'd3,
        ERR_SIZE_MISMATCH   = 3'd4,
        ERR_TIMEOUT         = 3'd5
    } tl_err_e;

    // Number of beats a message of log2-size 'size' occupies on a data_wd bus
    function automatic int unsigned tl_beats(input int unsigned size, input int unsigned data_wd);
        int unsigned lg;
        lg = $clog2(data_wd / 8);
        if (size > lg) begin
            return 32'd1 << (size - lg);
        end
        return 32'd1;
    endfunction

    // A opcodes that carry data (and so may span several beats)
    function automatic logic tl_a_multi(input logic [2:0] op);
        return (op <= A_LOGICAL_DATA);
    endfunction

    // D opcodes that carry data
    function automatic logic tl_d_multi(input logic [2:0] op);
        return (op == D_ACCESS_ACK_DATA) || (op == D_GRANT_DATA);
    endfunction

    // 1 when d_op is a legal response to a_op
    function automatic logic tl_expect_d(input logic [2:0] a_op, input logic [2:0] d_op);
        logic ok;
        case (a_op)
            A_PUT_FULL_DATA, A_PUT_PARTIAL_DATA: ok = (d_op == D_ACCESS_ACK);
            A_ARITHMETIC_DATA, A_LOGICAL_DATA:   ok = (d_op == D_ACCESS_ACK_DATA);
            A_GET:                               ok = (d_op == D_ACCESS_ACK_DATA);
            A_INTENT:                            ok = (d_op == D_HINT_ACK);
            A_ACQUIRE_BLOCK, A_ACQUIRE_PERM:     ok = (d_op == D_GRANT) || (d_op == D_GRANT_DATA);
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_beat_counter.sv
// ============================================================================
//  Module      : tl_beat_counter
//  Description : Tracks beat position within a TileLink message on one
//                channel and flags the first and last beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_beat_counter
    import tl_chk_pkg::*;
#(
    parameter int SIZE_WD = 3,
    parameter int DATA_WD = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_fire,
    input  logic               i_multi,
    input  logic [SIZE_WD-1:0] i_size,
    output logic               o_first,
    output logic               o_last
);

    // Wide enough for the largest possible beat index
    localparam int BEAT_WD = 2 ** SIZE_WD;

    logic [BEAT_WD-1:0] r_cnt;
    logic [BEAT_WD-1:0] w_total_m1;

    // Index of the final beat for the message currently on the wires
    always_comb begin
        w_total_m1 = '0;
        if (i_multi) begin
            w_total_m1 = BEAT_WD'(tl_beats(32'(i_size), DATA_WD) - 32'd1);
        end
    end

    assign o_first = (r_cnt == '0);
    assign o_last  = (r_cnt == w_total_m1);

    // Advance on each accepted beat, wrap to zero after the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_fire) begin
            r_cnt <= o_last ? '0 : r_cnt + BEAT_WD'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tl_inflight_checker.sv
// ============================================================================
//  Module      : tl_inflight_checker
//  Description : Per-source outstanding-request table on TileLink A/D that
//                flags duplicate sources, orphan responses, wrong response
//                opcode/size and response timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_inflight_checker
    import tl_chk_pkg::*;
#(
    parameter int SIZE_WD   = 3,
    parameter int SOURCE_WD = 4,
    parameter int DATA_WD   = 256,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WD    = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           a_opcode,
    input  logic [SIZE_WD-1:0]   a_size,
    input  logic [SOURCE_WD-1:0] a_source,
    input  logic                 a_valid,
    input  logic                 a_ready,
    input  logic [2:0]           d_opcode,
    input  logic [SIZE_WD-1:0]   d_size,
    input  logic [SOURCE_WD-1:0] d_source,
    input  logic                 d_denied,
    input  logic                 d_valid,
    input  logic                 d_ready,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic [SOURCE_WD-1:0] err_source,
    output logic [ERR_NUM-1:0]   err_sticky,
    output logic [SOURCE_WD:0]   inflight_cnt
);

    localparam int DEPTH  = 2 ** SOURCE_WD;
    localparam int INF_WD = SOURCE_WD + 1;

    // Outstanding-request table
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_timed_out;
    logic [DEPTH-1:0]   r_denied;
    logic [2:0]         r_op   [DEPTH];
    logic [SIZE_WD-1:0] r_size [DEPTH];
    logic [CNT_WD-1:0]  r_age  [DEPTH];

    logic                 r_err_valid;
    tl_err_e              r_err_code;
    logic [SOURCE_WD-1:0] r_err_source;
    logic [ERR_NUM-1:0]   r_sticky;
    logic [INF_WD-1:0]    r_inflight;

    logic w_a_fire, w_d_fire;
    logic w_a_first, w_a_last_unused, w_d_first, w_d_last;
    logic w_a_alloc, w_d_lookup, w_d_free, w_look_valid;
    logic [DEPTH-1:0]     w_alloc_oh, w_free_oh, w_valid_next, w_to_hit;
    logic [SOURCE_WD-1:0] w_to_src;
    logic [ERR_NUM-1:0]   w_err_vec;
    tl_err_e              w_code;
    logic [SOURCE_WD-1:0] w_src;
    logic [INF_WD-1:0]    w_cnt_next;

    assign w_a_fire = a_valid & a_ready;
    assign w_d_fire = d_valid & d_ready;

    tl_beat_counter #(.SIZE_WD(SIZE_WD), .DATA_WD(DATA_WD)) u_a_beats (
        .clk     (clock),
        .rst_n   (reset),
        .i_fire  (w_a_fire),
        .i_multi (tl_a_multi(a_opcode)),
        .i_size  (a_size),
        .o_first (w_a_first),
        .o_last  (w_a_last_unused)
    );

    tl_beat_counter #(.SIZE_WD(SIZE_WD), .DATA_WD(DATA_WD)) u_d_beats (
        .clk     (clock),
        .rst_n   (reset),
        .i_fire  (w_d_fire),
        .i_multi (tl_d_multi(d_opcode)),
        .i_size  (d_size),
        .o_first (w_d_first),
        .o_last  (w_d_last)
    );

    assign w_a_alloc    = w_a_fire & w_a_first;
    assign w_d_lookup   = w_d_fire & w_d_first;
    assign w_d_free     = w_d_fire & w_d_last;
    assign w_look_valid = r_valid[d_source];

    // One-hot allocate/free masks; free is applied before allocate
    always_comb begin
        w_alloc_oh = '0;
        w_free_oh  = '0;
        if (w_a_alloc) w_alloc_oh[a_source] = 1'b1;
        if (w_d_free)  w_free_oh[d_source]  = 1'b1;
        w_valid_next = w_alloc_oh | (r_valid & ~w_free_oh);
    end

    // Entries whose age reaches TIMEOUT-1 at this edge and have not yet reported
    always_comb begin
        w_to_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_to_hit[i] = r_valid[i] & ~r_timed_out[i] & ~w_alloc_oh[i] & ~w_free_oh[i]
                        & (r_age[i] == CNT_WD'(TIMEOUT - 2));
        end
    end

    // Priority encoder: lowest timed-out source index wins
    always_comb begin
        w_to_src = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_to_hit[i]) w_to_src = SOURCE_WD'(i);
        end
    end

    // Raw error flags, bit (code-1)
    always_comb begin
        w_err_vec    = '0;
        w_err_vec[0] = w_a_alloc & r_valid[a_source] & ~w_free_oh[a_source];
        w_err_vec[1] = w_d_lookup & ~w_look_valid;
        w_err_vec[2] = w_d_lookup & w_look_valid & ~tl_expect_d(r_op[d_source], d_opcode);
        w_err_vec[3] = w_d_lookup & w_look_valid & (d_size != r_size[d_source]);
        w_err_vec[4] = |w_to_hit;
    end

    // Report the lowest-numbered error of the cycle
    always_comb begin
        w_code = ERR_NONE;
        w_src  = '0;
        if (w_err_vec[0]) begin
            w_code = ERR_DUP_SOURCE;
            w_src  = a_source;
        end else if (w_err_vec[1]) begin
            w_code = ERR_ORPHAN_D;
            w_src  = d_source;
        end else if (w_err_vec[2]) begin
            w_code = ERR_OPCODE_MISMATCH;
            w_src  = d_source;
        end else if (w_err_vec[3]) begin
            w_code = ERR_SIZE_MISMATCH;
            w_src  = d_source;
        end else if (w_err_vec[4]) begin
            w_code = ERR_TIMEOUT;
            w_src  = w_to_src;
        end
    end

    // Population count of the next-cycle table
    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_next = w_cnt_next + INF_WD'(w_valid_next[i]);
        end
    end

    // Table state: allocate, free, age and timeout marking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid     <= '0;
            r_timed_out <= '0;
            r_denied    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= '0;
                r_size[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            r_valid     <= w_valid_next;
            r_timed_out <= (r_timed_out | w_to_hit) & ~w_alloc_oh & ~w_free_oh;
            if (w_d_lookup) begin
                r_denied[d_source] <= d_denied;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_oh[i]) begin
                    r_op[i]   <= a_opcode;
                    r_size[i] <= a_size;
                    r_age[i]  <= '0;
                end else if (w_free_oh[i]) begin
                    r_age[i]  <= '0;
                end else if (r_valid[i] && (r_age[i] != '1)) begin
                    r_age[i]  <= r_age[i] + CNT_WD'(1);
                end
            end
        end
    end

    // Registered error report, sticky summary and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err_valid  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_source <= '0;
            r_sticky     <= '0;
            r_inflight   <= '0;
        end else begin
            r_err_valid <= |w_err_vec;
            if (|w_err_vec) begin
                r_err_code   <= w_code;
                r_err_source <= w_src;
            end
            r_sticky   <= r_sticky | w_err_vec;
            r_inflight <= w_cnt_next;
        end
    end

    assign err_valid    = r_err_valid;
    assign err_code     = r_err_code;
    assign err_source   = r_err_source;
    assign err_sticky   = r_sticky;
    assign inflight_cnt = r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_tl_inflight_checker.sv
// ============================================================================
//  Module      : tb_tl_inflight_checker
//  Description : Directed scoreboard bench for tl_inflight_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl_inflight_checker;
    import tl_chk_pkg::*;

    localparam int SIZE_WD   = 3;
    localparam int SOURCE_WD = 4;
    localparam int DATA_WD   = 256;
    localparam int TIMEOUT   = 16;
    localparam int CNT_WD    = 11;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [2:0]           a_opcode, d_opcode;
    logic [SIZE_WD-1:0]   a_size, d_size;
    logic [SOURCE_WD-1:0] a_source, d_source;
    logic                 a_valid, a_ready, d_valid, d_ready, d_denied;
    logic                 err_valid;
    logic [2:0]           err_code;
    logic [SOURCE_WD-1:0] err_source;
    logic [4:0]           err_sticky;
    logic [SOURCE_WD:0]   inflight_cnt;

    typedef struct {
        logic [2:0] code;
        logic [3:0] src;
        logic [4:0] sticky;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_edge = 0;
    logic [4:0] exp_sticky = '0;

    tl_inflight_checker #(
        .SIZE_WD(SIZE_WD), .SOURCE_WD(SOURCE_WD), .DATA_WD(DATA_WD),
        .TIMEOUT(TIMEOUT), .CNT_WD(CNT_WD)
    ) dut (
        .clock(clock), .reset(reset),
        .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source),
        .d_denied(d_denied), .d_valid(d_valid), .d_ready(d_ready),
        .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
        .err_sticky(err_sticky), .inflight_cnt(inflight_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drv(input logic av, input logic [2:0] aop, input logic [2:0] asz,
                       input logic [3:0] asrc, input logic dv, input logic [2:0] dop,
                       input logic [2:0] dsz, input logic [3:0] dsrc);
        @(negedge clock);
        a_valid  = av;  a_opcode = aop; a_size = asz; a_source = asrc;
        d_valid  = dv;  d_opcode = dop; d_size = dsz; d_source = dsrc;
        last_edge = cyc + 1;
    endtask

    task automatic a_beat(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
        drv(1'b1, op, sz, src, 1'b0, '0, '0, '0);
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
        drv(1'b0, '0, '0, '0, 1'b1, op, sz, src);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            a_valid = 1'b0;
            d_valid = 1'b0;
        end
    endtask

    task automatic expect_err(input logic [2:0] code, input logic [3:0] src, input int at);
        exp_t e;
        exp_sticky = exp_sticky | (5'b1 << (code - 3'd1));
        e.code   = code;
        e.src    = src;
        e.sticky = exp_sticky;
        e.cyc    = at;
        q.push_back(e);
    endtask

    // Monitor: pop the scoreboard whenever the DUT reports an error
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("missed_err_cycle", cyc, e.cyc);
            end
            if (err_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_err: got code %0d src %0d, expected no error (cycle %0d)",
                             err_code, err_source, cyc);
                end else begin
                    e = q.pop_front();
                    chk("err_code",   int'(err_code),   int'(e.code));
                    chk("err_source", int'(err_source), int'(e.src));
                    chk("err_sticky", int'(err_sticky), int'(e.sticky));
                    chk("err_cycle",  cyc,              e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        a_valid = 1'b0; a_ready = 1'b1; a_opcode = '0; a_size = '0; a_source = '0;
        d_valid = 1'b0; d_ready = 1'b1; d_opcode = '0; d_size = '0; d_source = '0;
        d_denied = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_err_valid",  int'(err_valid),    0);
        chk("rst_err_code",   int'(err_code),     0);
        chk("rst_err_source", int'(err_source),   0);
        chk("rst_err_sticky", int'(err_sticky),   0);
        chk("rst_inflight",   int'(inflight_cnt), 0);
        reset = 1'b1;

        // Get src3 size6, two-beat AccessAckData
        a_beat(A_GET, 3'd6, 4'd3);
        idle(1); chk("get_alloc_cnt", int'(inflight_cnt), 1);
        d_beat(D_ACCESS_ACK_DATA, 3'd6, 4'd3);
        idle(1); chk("d_first_beat_cnt", int'(inflight_cnt), 1);
        d_beat(D_ACCESS_ACK_DATA, 3'd6, 4'd3);
        idle(1); chk("d_last_beat_cnt", int'(inflight_cnt), 0);

        // A valid without ready must not allocate
        a_ready = 1'b0;
        a_beat(A_GET, 3'd5, 4'd9);
        idle(1); a_ready = 1'b1;
        chk("no_ready_cnt", int'(inflight_cnt), 0);

        // Two-beat PutFullData src2, then Get src2 before the response
        a_beat(A_PUT_FULL_DATA, 3'd6, 4'd2);
        a_beat(A_PUT_FULL_DATA, 3'd6, 4'd2);
        a_beat(A_GET, 3'd5, 4'd2);
        expect_err(3'd1, 4'd2, last_edge);
        idle(1); chk("dup_cnt", int'(inflight_cnt), 1);
        d_beat(D_ACCESS_ACK_DATA, 3'd5, 4'd2);
        idle(1); chk("dup_clean_cnt", int'(inflight_cnt), 0);

        // Orphan AccessAck src7
        d_beat(D_ACCESS_ACK, 3'd3, 4'd7);
        expect_err(3'd2, 4'd7, last_edge);
        idle(1); chk("orphan_cnt", int'(inflight_cnt), 0);

        // Get answered with AccessAck
        a_beat(A_GET, 3'd6, 4'd1);
        d_beat(D_ACCESS_ACK, 3'd6, 4'd1);
        expect_err(3'd3, 4'd1, last_edge);
        idle(1); chk("opc_cnt", int'(inflight_cnt), 0);

        // Get size5 answered with size6 (two beats)
        a_beat(A_GET, 3'd5, 4'd1);
        d_beat(D_ACCESS_ACK_DATA, 3'd6, 4'd1);
        expect_err(3'd4, 4'd1, last_edge);
        d_beat(D_ACCESS_ACK_DATA, 3'd6, 4'd1);
        idle(1); chk("size_cnt", int'(inflight_cnt), 0);

        // AcquireBlock src4 with no response: one timeout pulse
        a_beat(A_ACQUIRE_BLOCK, 3'd6, 4'd4);
        expect_err(3'd5, 4'd4, last_edge + TIMEOUT - 1);
        idle(20); chk("timeout_still_valid", int'(inflight_cnt), 1);
        d_beat(D_GRANT_DATA, 3'd6, 4'd4);
        d_beat(D_GRANT_DATA, 3'd6, 4'd4);
        idle(1); chk("timeout_clean_cnt", int'(inflight_cnt), 0);

        // Same-cycle free and re-allocate of src5
        a_beat(A_GET, 3'd5, 4'd5);
        idle(1); chk("src5_alloc_cnt", int'(inflight_cnt), 1);
        drv(1'b1, A_GET, 3'd5, 4'd5, 1'b1, D_ACCESS_ACK_DATA, 3'd5, 4'd5);
        idle(1); chk("free_alloc_cnt", int'(inflight_cnt), 1);

        // Reset in the middle of a four-beat Put
        a_beat(A_PUT_FULL_DATA, 3'd7, 4'd6);
        a_beat(A_PUT_FULL_DATA, 3'd7, 4'd6);
        #2 reset = 1'b0;
        #1;
        chk("midrst_inflight", int'(inflight_cnt), 0);
        chk("midrst_sticky",   int'(err_sticky),   0);
        chk("midrst_valid",    int'(err_valid),    0);
        a_valid = 1'b0; d_valid = 1'b0;
        exp_sticky = '0;
        @(negedge clock);
        reset = 1'b1;

        // Late GrantData on src5 is now an orphan
        d_beat(D_GRANT_DATA, 3'd6, 4'd5);
        expect_err(3'd2, 4'd5, last_edge);
        d_beat(D_GRANT_DATA, 3'd6, 4'd5);
        idle(3); chk("post_rst_cnt", int'(inflight_cnt), 0);

        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
